// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   master : operand producer / result consumer (drives in_valid, a, b, cin, out_ready)
//   slave  : the adder (drives in_ready, out_valid, sum, cout and, with
//            SERIAL_ADDER_OVF_EN defined, ovf)
// WIDTH must match the WIDTH parameter of the attached serial_adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit unsigned operands plus carry-in, DIGIT bits
// per clock through a single DIGIT-wide carry slice. Result is registered and
// offered on a valid/ready handshake.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort back to IDLE (sum/cout keep their values)
//   bus   : serial_adder_if.slave -- in_valid/in_ready/a/b/cin operand side,
//           out_valid/out_ready/sum/cout(/ovf) result side
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf, registered together with sum.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    serial_adder_if.slave  bus
);
    localparam int unsigned NDIG     = WIDTH / DIGIT;
    localparam int unsigned CNT_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             load_c;
    logic             step_c;
    logic             finish_c;

    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             a_msb_q;
    logic             b_msb_q;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [DIGIT:0]         dsum_c;
    logic [WIDTH+DIGIT-1:0] sum_cat_c;
    logic [WIDTH-1:0]       sum_sh_next_c;

    // One DIGIT-wide carry slice: low digit of each operand plus running carry.
    assign dsum_c = (DIGIT+1)'(a_sh_q[DIGIT-1:0])
                  + (DIGIT+1)'(b_sh_q[DIGIT-1:0])
                  + (DIGIT+1)'(carry_q);

    // New digit enters from the MSB side; after NDIG steps digit 0 sits at the LSB.
    assign sum_cat_c     = {dsum_c[DIGIT-1:0], sum_sh_q};
    assign sum_sh_next_c = sum_cat_c[WIDTH+DIGIT-1:DIGIT];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes; clr overrides every transition.
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        finish_c = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        load_c  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    step_c = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        finish_c = 1'b1;
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Serial datapath: operand shift registers, carry, digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else if (load_c) begin
            a_sh_q   <= bus.a;
            b_sh_q   <= bus.b;
            carry_q  <= bus.cin;
            cnt_q    <= '0;
            a_msb_q  <= bus.a[WIDTH-1];
            b_msb_q  <= bus.b[WIDTH-1];
        end else if (step_c) begin
            a_sh_q   <= a_sh_q >> DIGIT;
            b_sh_q   <= b_sh_q >> DIGIT;
            sum_sh_q <= sum_sh_next_c;
            carry_q  <= dsum_c[DIGIT];
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // Handshake flags follow the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Result registers load only on DONE entry and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (finish_c) begin
            sum_q  <= sum_sh_next_c;
            cout_q <= dsum_c[DIGIT];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (finish_c) begin
            ovf_q <= (a_msb_q == b_msb_q) && (sum_sh_next_c[WIDTH-1] != a_msb_q);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule
